// File: rtl/cpu_op_sequencer_pkg.sv
// cpu_op_sequencer_pkg: shared op word types and sequencer states
package cpu_op_sequencer_pkg;

    typedef enum logic [2:0] {
        NO_OP        = 3'd0,
        OP_CT_CT_ADD = 3'd1,
        OP_CT_PT_ADD = 3'd2,
        OP_CT_PT_MUL = 3'd3
    } op_e;

    typedef struct packed {
        op_e        mode;
        logic [3:0] dst_idx;
        logic [3:0] src0_idx;
        logic [3:0] src1_idx;
    } operation;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_PREP,
        SEQ_ISSUE,
        SEQ_RETIRE,
        SEQ_ERROR
    } seq_state_e;

    localparam int SEQ_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/cpu_op_sequencer_op_fifo.sv
// op_fifo: synchronous FIFO with head and head+1 peek ports
module op_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = logic [7:0]
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  T                       din,
    output T                       head,
    output T                       head_nxt,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    T mem_q [DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic push_en, pop_en;

    always_comb begin
        level    = wr_q - rd_q;
        full     = level == (AW+1)'(DEPTH);
        empty    = level == '0;
        push_en  = push & ~full;
        pop_en   = pop & ~empty;
        wr_d     = push_en ? wr_q + (AW+1)'(1) : wr_q;
        rd_d     = pop_en ? rd_q + (AW+1)'(1) : rd_q;
        head     = mem_q[rd_q[AW-1:0]];
        head_nxt = mem_q[rd_q[AW-1:0] + AW'(1)];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/cpu_op_sequencer.sv
// cpu_op_sequencer: buffers host ops and issues them one at a time to the cpu
module cpu_op_sequencer
    import cpu_op_sequencer_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = SEQ_TIMEOUT_CYC,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  operation               in_op,
    output operation               cpu_op,
    output logic                   cpu_soft_rst,
    input  logic                   cpu_done,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level,
    output logic [CNT_W-1:0]       retired,
    output logic                   err,
    input  logic                   err_clear
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int WW = $clog2(TIMEOUT_CYC) + 1;

    seq_state_e state_q, state_d;
    logic [WW-1:0] wd_q, wd_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic pop, full, empty;
    operation head, head_nxt;

    op_fifo #(.DEPTH(DEPTH), .T(operation)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(in_valid & in_ready),
        .pop(pop),
        .din(in_op),
        .head(head),
        .head_nxt(head_nxt),
        .level(level),
        .full(full),
        .empty(empty)
    );

    always_comb begin
        state_d      = state_q;
        wd_d         = wd_q;
        retired_d    = retired_q;
        pop          = 1'b0;
        cpu_op       = '0;
        cpu_soft_rst = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                if (!empty && head.mode == NO_OP) begin
                    pop       = 1'b1;
                    retired_d = retired_q + CNT_W'(1);
                end else if (!empty) begin
                    state_d = SEQ_PREP;
                end
            end
            SEQ_PREP: begin
                cpu_soft_rst = 1'b1;
                wd_d         = '0;
                state_d      = SEQ_ISSUE;
            end
            SEQ_ISSUE: begin
                cpu_op  = head;
                wd_d    = wd_q + WW'(1);
                state_d = cpu_done ? SEQ_RETIRE :
                          (wd_q == WW'(TIMEOUT_CYC - 1)) ? SEQ_ERROR : SEQ_ISSUE;
            end
            SEQ_RETIRE: begin
                pop       = 1'b1;
                retired_d = retired_q + CNT_W'(1);
                // a queued NO_OP is left for IDLE to drain
                state_d   = (level > LW'(1) && head_nxt.mode != NO_OP) ? SEQ_PREP : SEQ_IDLE;
            end
            SEQ_ERROR: begin
                pop     = err_clear;
                state_d = err_clear ? SEQ_IDLE : SEQ_ERROR;
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= SEQ_IDLE;
            wd_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            retired_q <= retired_d;
        end
    end

    assign in_ready = ~full;
    assign err      = state_q == SEQ_ERROR;
    assign busy     = (state_q != SEQ_IDLE) | ~empty;
    assign retired  = retired_q;

endmodule

// File: tb/tb_cpu_op_sequencer.sv
// tb_cpu_op_sequencer: scoreboard bench with a latency-programmable cpu model
module tb_cpu_op_sequencer;
    import cpu_op_sequencer_pkg::*;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    operation in_op = '0;
    operation cpu_op;
    logic cpu_soft_rst;
    logic cpu_done;
    logic busy;
    logic [3:0] level;
    logic [15:0] retired;
    logic err;
    logic err_clear = 1'b0;

    logic model_done = 1'b0;
    logic force_done = 1'b0;
    assign cpu_done = model_done | force_done;

    int total = 0;
    int bad = 0;
    operation exp_issue[$];
    int lat_q[$];
    int exp_retired = 0;
    int cur_lat = 0;
    int cnt = 0;

    cpu_op_sequencer #(.DEPTH(8), .TIMEOUT_CYC(TO), .CNT_W(16)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_op(in_op),
        .cpu_op(cpu_op),
        .cpu_soft_rst(cpu_soft_rst),
        .cpu_done(cpu_done),
        .busy(busy),
        .level(level),
        .retired(retired),
        .err(err),
        .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    // cpu model: each issued op takes the next latency from lat_q (0 = never done)
    always @(negedge clk) begin
        if (cpu_op.mode != NO_OP) begin
            if (cnt == 0) cur_lat = (lat_q.size() != 0) ? lat_q.pop_front() : 0;
            cnt++;
        end else begin
            cnt = 0;
        end
        model_done = (cnt != 0) && (cnt == cur_lat);
    end

    logic in_iss = 1'b0;
    logic prev_soft = 1'b0;
    int len = 0;
    operation held;

    always @(posedge clk) begin
        #1;
        if (reset) begin
            in_iss = 1'b0;
            prev_soft = 1'b0;
        end else begin
            if (cpu_op.mode != NO_OP) begin
                if (!in_iss) begin
                    chk("soft_rst_before_issue", prev_soft, 1);
                    if (exp_issue.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_issue: got %0h want none", cpu_op);
                    end else begin
                        chk("issue_op", cpu_op, exp_issue.pop_front());
                    end
                    held = cpu_op;
                    len = 1;
                    in_iss = 1'b1;
                end else begin
                    chk("op_hold", cpu_op, held);
                    len++;
                end
            end else if (in_iss) begin
                in_iss = 1'b0;
                chk("err_on_end", err, cur_lat == 0);
                chk("issue_len", len, (cur_lat == 0) ? TO : cur_lat);
            end
            prev_soft = cpu_soft_rst;
        end
    end

    function automatic operation mk(input op_e m, input int d, input int a, input int b);
        operation o;
        o.mode = m;
        o.dst_idx = 4'(d);
        o.src0_idx = 4'(a);
        o.src1_idx = 4'(b);
        return o;
    endfunction

    task automatic push(input operation o, input int lat);
        int k = 0;
        in_op = o;
        in_valid = 1'b1;
        while (!in_ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("push_accept_timeout", k < 400, 1);
        if (o.mode != NO_OP) begin
            exp_issue.push_back(o);
            lat_q.push_back(lat);
        end
        exp_retired++;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string n);
        int k = 0;
        while (busy && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk({n, "_drain"}, k < 3000, 1);
        chk({n, "_retired"}, retired, 16'(exp_retired));
        chk({n, "_level"}, level, 0);
        chk({n, "_pending"}, exp_issue.size(), 0);
        chk({n, "_cpu_op"}, cpu_op, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        logic [5:0] trace [6];
        logic [5:0] want [6];
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_level", level, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_cpu_op", cpu_op, 0);
        chk("rst_soft", cpu_soft_rst, 0);
        chk("rst_busy", busy, 0);
        chk("rst_retired", retired, 0);
        chk("rst_err", err, 0);

        // single add: IDLE, PREP, ISSUE x2, RETIRE, IDLE; bits {soft, issuing, busy}
        push(mk(OP_CT_CT_ADD, 1, 2, 3), 2);
        want = '{6'b001, 6'b101, 6'b011, 6'b011, 6'b001, 6'b000};
        for (int i = 0; i < 6; i++) begin
            trace[i] = {3'b0, cpu_soft_rst, cpu_op.mode != NO_OP, busy};
            @(negedge clk);
        end
        for (int i = 0; i < 6; i++) chk($sformatf("single_cycle%0d", i), trace[i], want[i]);
        wait_idle("single");

        // fill the FIFO while the first op is slow
        for (int i = 0; i < 8; i++) push(mk(OP_CT_PT_ADD, i, i + 1, 15 - i), 14);
        chk("fill_level", level, 8);
        chk("fill_in_ready", in_ready, 0);
        in_op = mk(OP_CT_PT_MUL, 9, 9, 9);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_idle("fill");

        push(mk(OP_CT_PT_MUL, 5, 6, 7), 12);
        push(mk(OP_CT_PT_ADD, 8, 9, 10), 2);
        wait_idle("mul_add");

        push(mk(OP_CT_CT_ADD, 3, 4, 5), 2);
        push(mk(NO_OP, 0, 0, 0), 0);
        push(mk(OP_CT_CT_ADD, 6, 7, 8), 2);
        wait_idle("noop");

        for (int i = 0; i < 24; i++) begin
            op_e m = op_e'($urandom_range(0, 3));
            push(mk(m, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15)),
                 $urandom_range(1, 10));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle("random");

        // watchdog: first op never completes
        push(mk(OP_CT_PT_MUL, 1, 1, 1), 0);
        push(mk(OP_CT_CT_ADD, 2, 2, 2), 3);
        begin
            int k = 0;
            while (!err && k < 100) begin
                @(negedge clk);
                k++;
            end
            chk("err_wait", k < 100, 1);
        end
        chk("err_level", level, 2);
        chk("err_retired", retired, 16'(exp_retired - 2));
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        chk("err_cleared", err, 0);
        exp_retired--;
        wait_idle("err");

        // reset while an op is hung in ISSUE
        for (int i = 0; i < 3; i++) push(mk(OP_CT_PT_ADD, i, i, i), 0);
        begin
            int k = 0;
            while (cpu_op.mode == NO_OP && k < 50) begin
                @(negedge clk);
                k++;
            end
            chk("rst_mid_issue_wait", k < 50, 1);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_issue.delete();
        lat_q.delete();
        exp_retired = 0;
        chk("rst_mid_level", level, 0);
        chk("rst_mid_retired", retired, 0);
        chk("rst_mid_cpu_op", cpu_op, 0);
        chk("rst_mid_err", err, 0);
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid_late_done", retired, 0);
        chk("rst_mid_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
